// File: rtl/cpu_pkg.sv
// Shared definitions for the 10-bit CPU: opcode/halt encodings and fetch FSM states.
package cpu_pkg;

  localparam int unsigned PC_W      = 10;
  localparam int unsigned JMP_TGT_W = 6;

  localparam logic [3:0]      OP_JUMP   = 4'b1000;
  localparam logic [PC_W-1:0] HALT_WORD = 10'b0010000010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// Combinational next-PC select: redirect > hold (stall/halt) > jump > increment.
module fetch_pc_sel
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_run,
  input  logic            i_stall,
  input  logic            i_redirect_valid,
  input  logic [PC_W-1:0] i_redirect_addr,
  input  logic [PC_W-1:0] i_word,
  output logic [PC_W-1:0] o_next_pc,
  output logic            o_is_halt
);

  // Priority mux for the next PC; outside RUN the PC never moves.
  always_comb begin
    o_is_halt = (i_word == HALT_WORD);
    o_next_pc = i_pc;
    if (i_run) begin
      if (i_redirect_valid) begin
        o_next_pc = i_redirect_addr;
      end else if (i_stall || o_is_halt) begin
        o_next_pc = i_pc;
      end else if (i_word[PC_W-1:JMP_TGT_W] == OP_JUMP) begin
        o_next_pc = {{(PC_W-JMP_TGT_W){1'b0}}, i_word[JMP_TGT_W-1:0]};
      end else begin
        o_next_pc = i_pc + PC_W'(1);
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, ROM address, instruction register, halt freeze.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [9:0]  RESET_PC = 10'd0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [9:0]       address,
  input  logic [9:0]       read_data,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [9:0]       redirect_addr,
  output logic [9:0]       instr,
  output logic [9:0]       instr_pc,
  output logic             instr_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  fetch_state_t     r_state;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_instr;
  logic [PC_W-1:0]  r_instr_pc;
  logic             r_instr_valid;
  logic             r_halted;
  logic [CNT_W-1:0] r_fetch_count;

  logic [PC_W-1:0]  w_next_pc;
  logic             w_is_halt;
  logic             w_run;

  assign w_run = (r_state == RUN);

  fetch_pc_sel u_pc_sel (
    .i_pc             (r_pc),
    .i_run            (w_run),
    .i_stall          (stall),
    .i_redirect_valid (redirect_valid),
    .i_redirect_addr  (redirect_addr),
    .i_word           (read_data),
    .o_next_pc        (w_next_pc),
    .o_is_halt        (w_is_halt)
  );

  // FSM, PC and instruction register update; redirect squashes, stall holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= RUN;
        end
        RUN: begin
          r_pc <= w_next_pc;
          if (redirect_valid) begin
            r_instr_valid <= 1'b0;
          end else if (!stall) begin
            r_instr       <= read_data;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            if (r_fetch_count != '1) begin
              r_fetch_count <= r_fetch_count + CNT_W'(1);
            end
            if (w_is_halt) begin
              r_state  <= HALTED;
              r_halted <= 1'b1;
            end
          end
        end
        HALTED: begin
          r_instr_valid <= 1'b0;
          r_halted      <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign address     = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;
  assign fetch_count = r_fetch_count;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 10-bit CPU. Owns the program counter, drives the combinational instruction ROM address, and registers each returned word into an instruction register for decode. Resolves unconditional jumps locally, accepts branch redirects from execute, honours decode stalls, and freezes on the halt word.

## Interface
Parameters:
- `RESET_PC`, 10'd0: PC loaded on reset. ROM word 0 is the reset-timing slot.
- `CNT_W`, 16: width of the fetched-instruction counter.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `address`  out  10: ROM address; always equals the internal `pc`.
- `read_data`  in  10: ROM word; combinational from `address` in the same cycle.
- `stall`  in  1: decode cannot accept; hold the IR and the PC.
- `redirect_valid`  in  1: taken branch from execute.
- `redirect_addr`  in  10: branch target.
- `instr`  out  10: instruction register.
- `instr_pc`  out  10: address `instr` was fetched from.
- `instr_valid`  out  1: `instr` is live for decode.
- `halted`  out  1: halt word has been fetched; fetch is frozen.
- `fetch_count`  out  CNT_W: number of words captured with valid = 1.

## Operation
- States: IDLE, RUN, HALTED.
- **IDLE**
  - Entered on every cycle with `rst` = 1.
  - First cycle after `rst` deasserts: capture nothing, go to RUN. This is the reset-timing slot.
- **RUN, no stall, no redirect**
  - `instr` <= `read_data`; `instr_pc` <= `pc`; `instr_valid` <= 1; `fetch_count` += 1.
  - Next PC:
    - Jump (`read_data[9:6]` = 4'b1000): `pc` <= {4'b0000, `read_data[5:0]`}. The jump word is still forwarded valid; decode treats it as a no-op.
    - Otherwise: `pc` <= `pc` + 1, modulo 1024. Address 1023 wraps to 0.
  - Halt word (10'b0010000010): capture it valid, `pc` holds, go to HALTED.
- **RUN, stall = 1, no redirect**
  - `pc`, `instr`, `instr_pc`, `instr_valid` and `fetch_count` all hold.
  - Halt and jump detection are suppressed.
- **RUN, redirect_valid = 1**
  - Has priority over `stall`, jump and halt decoding.
  - `pc` <= `redirect_addr`; `instr_valid` <= 0 (squashes the wrong-path word); `instr`/`instr_pc` hold; no count.
  - A halt fetched in the same cycle is discarded.
- **HALTED**
  - `halted` = 1; `instr_valid` <= 0 on the next cycle.
  - `pc` frozen; `redirect_valid` and `stall` ignored. Exit only via `rst`.
- Arithmetic: all PC arithmetic is unsigned 10-bit and wraps. `fetch_count` saturates at all-ones.

## Timing
- Reset values: `pc` = `RESET_PC`; `address` = `RESET_PC`; `instr` = 0; `instr_pc` = 0; `instr_valid` = 0; `halted` = 0; `fetch_count` = 0; state IDLE.
- Latency: a word at address A presented in cycle n appears on `instr` / `instr_valid` in cycle n+1.
- Jump cost: no bubble; the target address is presented in the cycle after the jump word.
- Redirect cost: one bubble (`instr_valid` = 0 for one cycle). The target word is valid two cycles after the redirect.
- `rst` asserted mid-run, including in HALTED: all registers take reset values on that edge; the in-flight word is dropped.
- Outputs are registered, except `address`, which is the `pc` register itself. No combinational path from `read_data` to any output.

## Structure
- Shared package `cpu_pkg`:
  - `OP_JUMP` = 4'b1000
  - `HALT_WORD` = 10'b0010000010
  - `JMP_TGT_W` = 6
  - fetch state enum {IDLE, RUN, HALTED}
- One sub-module, `fetch_pc_sel`: a combinational next-PC mux (redirect > halt-hold > jump > increment). Unit-tested separately.

## Test plan
- Reset then run over the task program. Expect `address` 0,1,2,3; `instr` 0, 10'b1101110000, 10'b1101101101 in consecutive cycles; `instr_pc` 0,1,2; `fetch_count` = 3.
- Jump: `pc` reaches 7 (word 10'b1000001001). Next `address` = 9, `instr_valid` stays 1, `instr_pc` of the following word = 9. Same check for word 18 → `address` 3.
- Stall 3 cycles at `pc` = 12: `address`, `instr` and `fetch_count` constant for 3 cycles; resume at 13.
- Redirect to 28 while `stall` = 1: next `address` = 28; `instr_valid` = 0 for one cycle; word 10'b1100101101 is valid with `instr_pc` = 28.
- Halt at 40: `instr` = 10'b0010000010 valid; `halted` = 1 next cycle, then `instr_valid` = 0. `address` remains 40 for 10 cycles, with redirects to 5 ignored.
- Wrap and reset: force `RESET_PC` = 1023 with a non-jump word; next `address` = 0. Assert `rst` mid-run: next cycle all outputs are at reset values, then IDLE is followed by RUN.
